l2_pmem_adapter: RTL and testbench

- Bridges the L2 cache's single-cycle, line-wide memory port to the burst-oriented physical memory port.
- L2 side: the L2 controller drives one full 256-bit line write, or requests one full line read, at a time.
- Memory side: the adapter issues the line as BEATS consecutive 64-bit beats, or collects it from BEATS beats, and signals line completion back to L2 with a one-cycle response.
- Sits between the L2 controller/datapath and the pmem interface.

---
 rtl/l2_pmem_adapter.sv | 116 +++++++++++
 tb/tb_l2_pmem_adapter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_pmem_adapter.sv
// Bridges the L2 line-wide memory port to a burst-oriented physical memory port.
// A line goes out as BEATS write beats or is assembled from BEATS read beats, then L2 gets a one-cycle response.
module l2_pmem_adapter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               l2_read_i,
    input  logic               l2_write_i,
    input  logic [ADDR_W-1:0]  l2_address_i,
    input  logic [LINE_W-1:0]  l2_line_i,
    output logic [LINE_W-1:0]  l2_line_o,
    output logic               l2_resp_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [ADDR_W-1:0]  mem_address_o,
    output logic [BURST_W-1:0] mem_burst_o,
    input  logic [BURST_W-1:0] mem_burst_i,
    input  logic               mem_resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr;
    logic [LINE_W-1:0]  wline;
    logic [IDX_W-1:0]   base;
    logic               last_beat;

    assign mem_address_o = addr;
    assign last_beat     = (cnt == CNT_W'(BEATS - 1));

    // The counter stops on the terminal beat instead of wrapping, so it never leaves the line.
    always_comb begin
        state_next  = state;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_burst_o = '0;
        l2_resp_o   = 1'b0;
        base        = IDX_W'(cnt * BURST_W);
        case (state)
            IDLE: begin
                if (l2_write_i) begin
                    state_next = WRITE;
                end else if (l2_read_i) begin
                    state_next = READ;
                end
            end
            READ: begin
                mem_read_o = 1'b1;
                if (mem_resp_i && last_beat) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                mem_write_o = 1'b1;
                mem_burst_o = wline[base +: BURST_W];
                if (mem_resp_i && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                l2_resp_o  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr      <= '0;
            wline     <= '0;
            l2_line_o <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (l2_write_i || l2_read_i) begin
                        addr <= l2_address_i & ~OFF_MASK;
                        cnt  <= '0;
                        if (l2_write_i) begin
                            wline <= l2_line_i;
                        end
                    end
                end
                READ: begin
                    if (mem_resp_i) begin
                        l2_line_o[base +: BURST_W] <= mem_burst_i;
                        if (!last_beat) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_resp_i && !last_beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_pmem_adapter.sv
// Scoreboard bench for l2_pmem_adapter: the driver queues expected beats and responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_l2_pmem_adapter;

    logic         clk;
    logic         rst;
    logic         l2_read_i;
    logic         l2_write_i;
    logic [31:0]  l2_address_i;
    logic [255:0] l2_line_i;
    logic [255:0] l2_line_o;
    logic         l2_resp_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [31:0]  mem_address_o;
    logic [63:0]  mem_burst_o;
    logic [63:0]  mem_burst_i;
    logic         mem_resp_i;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        logic [255:0] line;
        int           cycle;
    } resp_t;

    beat_t        beat_q[$];
    resp_t        resp_q[$];
    int           tests;
    int           fails;
    int           cyc;
    logic [255:0] last_line;
    logic [255:0] rd_line;
    int           rd_idx;
    bit           gap_mode;
    bit           phase;
    bit           stray;

    l2_pmem_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .l2_read_i    (l2_read_i),
        .l2_write_i   (l2_write_i),
        .l2_address_i (l2_address_i),
        .l2_line_i    (l2_line_i),
        .l2_line_o    (l2_line_o),
        .l2_resp_o    (l2_resp_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_address_o(mem_address_o),
        .mem_burst_o  (mem_burst_o),
        .mem_burst_i  (mem_burst_i),
        .mem_resp_i   (mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Memory model: answers beats one cycle per beat, or every other cycle when gap_mode is set.
    initial begin
        mem_resp_i  = 1'b0;
        mem_burst_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mem_resp_i = 1'b0;
            end else if (mem_read_o || mem_write_o) begin
                if (!gap_mode || phase) begin
                    mem_resp_i = 1'b1;
                    if (mem_read_o && rd_idx < 4) begin
                        mem_burst_i = rd_line[rd_idx*64 +: 64];
                        rd_idx++;
                    end
                end else begin
                    mem_resp_i = 1'b0;
                end
                phase = ~phase;
            end else begin
                mem_resp_i = stray;
            end
        end
    end

    // Monitor: every response and every accepted beat must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (l2_resp_o) begin
                if (resp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_resp: l2_resp_o=1 at cycle %0d, expected no response", cyc);
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    checkOutput("resp_line", l2_line_o, e.line);
                    if (e.cycle >= 0) checkOutput("resp_cycle", 256'(cyc), 256'(e.cycle));
                    checkOutput("req_low_in_done", {254'd0, mem_read_o, mem_write_o}, '0);
                end
            end
            if ((mem_read_o || mem_write_o) && mem_resp_i) begin
                if (beat_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_beat: beat accepted at cycle %0d, expected none", cyc);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    checkOutput("beat_is_write", 256'(mem_write_o), 256'(b.is_write));
                    checkOutput("beat_addr", 256'(mem_address_o), 256'(b.addr));
                    if (b.is_write) checkOutput("beat_data", 256'(mem_burst_o), 256'(b.data));
                end
            end else if (mem_write_o && beat_q.size() > 0) begin
                checkOutput("stall_hold_data", 256'(mem_burst_o), 256'(beat_q[0].data));
            end
        end
    end

    // One L2 transaction (write, read or both at once); abort resets the DUT after two read beats.
    task automatic applyStimulus(input bit do_read, input bit do_write, input logic [31:0] addr,
                                 input logic [255:0] line, input logic [255:0] rdl,
                                 input bit gap, input bit scramble, input bit abort);
        int          t0;
        int          n;
        int          seen;
        bit          finished;
        logic [31:0] aligned;
        @(posedge clk);
        #2;
        gap_mode = gap;
        phase    = 1'b0;
        rd_idx   = 0;
        rd_line  = rdl;
        t0       = cyc;
        aligned  = addr & 32'hFFFF_FFE0;
        if (do_write) begin
            for (int i = 0; i < 4; i++) beat_q.push_back('{1'b1, aligned, line[i*64 +: 64]});
            resp_q.push_back('{last_line, gap ? -1 : t0 + 5});
        end
        if (do_read) begin
            for (int i = 0; i < 4; i++) beat_q.push_back('{1'b0, aligned, 64'd0});
            resp_q.push_back('{rdl, gap ? -1 : (do_write ? t0 + 11 : t0 + 5)});
            last_line = rdl;
        end
        l2_address_i = addr;
        l2_line_i    = line;
        l2_read_i    = do_read;
        l2_write_i   = do_write;
        n        = 0;
        seen     = 0;
        finished = 1'b0;
        while (!finished && n < 60) begin
            @(posedge clk);
            #2;
            n++;
            if (n == 1 && scramble) begin
                l2_address_i = 32'hFFFF_FFC0;
                l2_line_i    = ~line;
            end
            if (abort) begin
                if (seen == 2) begin
                    rst       = 1'b1;
                    l2_read_i = 1'b0;
                    @(posedge clk);
                    #2;
                    rst = 1'b0;
                    beat_q.delete();
                    resp_q.delete();
                    last_line = '0;
                    checkOutput("abort_mem_read", 256'(mem_read_o), 256'(0));
                    checkOutput("abort_line", l2_line_o, '0);
                    checkOutput("abort_resp", 256'(l2_resp_o), 256'(0));
                    repeat (6) @(posedge clk);
                    finished = 1'b1;
                end else if (mem_read_o && mem_resp_i) begin
                    seen++;
                end
            end else if (l2_resp_o) begin
                if (l2_write_i) l2_write_i = 1'b0;
                else l2_read_i = 1'b0;
                finished = !l2_read_i && !l2_write_i;
            end
        end
        if (!finished) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout: no completion after %0d cycles, expected l2_resp_o", n);
            l2_read_i  = 1'b0;
            l2_write_i = 1'b0;
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        cyc          = 0;
        last_line    = '0;
        rd_line      = '0;
        rd_idx       = 0;
        gap_mode     = 1'b0;
        phase        = 1'b0;
        stray        = 1'b0;
        rst          = 1'b1;
        l2_read_i    = 1'b0;
        l2_write_i   = 1'b0;
        l2_address_i = '0;
        l2_line_i    = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        checkOutput("rst_line", l2_line_o, '0);
        checkOutput("rst_resp", 256'(l2_resp_o), 256'(0));
        checkOutput("rst_mem_read", 256'(mem_read_o), 256'(0));
        checkOutput("rst_mem_write", 256'(mem_write_o), 256'(0));
        checkOutput("rst_mem_addr", 256'(mem_address_o), 256'(0));
        checkOutput("rst_mem_burst", 256'(mem_burst_o), 256'(0));

        stray = 1'b1;
        repeat (4) @(posedge clk);
        stray = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("stray_mem_read", 256'(mem_read_o), 256'(0));
        checkOutput("stray_mem_write", 256'(mem_write_o), 256'(0));
        checkOutput("stray_line", l2_line_o, '0);

        applyStimulus(1'b1, 1'b0, 32'h0000_1234, '0,
                      {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, 1'b0, 1'b0);
        checkOutput("read_line_hold", l2_line_o,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        applyStimulus(1'b0, 1'b1, 32'h0000_805F,
                      {64'h0F1E_2D3C_4B5A_6978, 64'hDEAD_BEEF_CAFE_F00D,
                       64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, '0, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 32'h0000_2008,
                      {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                       64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0},
                      {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
                       64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0}, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'h0000_4000, '0,
                      {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                       64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0}, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'h0000_5010, '0,
                      {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                       64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0}, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 32'h0000_6004,
                      {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
                       64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0}, '0, 1'b0, 1'b1, 1'b0);

        repeat (4) @(posedge clk);
        #2;
        checkOutput("resp_q_drained", 256'(resp_q.size()), 256'(0));
        checkOutput("beat_q_drained", 256'(beat_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
